// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the BNN weight-load transmitter.
package bnn_pkg;

  localparam int NUM_NEURONS = 8;
  localparam int WEIGHT_W    = 8;
  localparam int NIBBLE_W    = 4;
  localparam int GAP_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    GAP
  } state_e;

endpackage

// File: rtl/bnn_weight_streamer.sv
// Buffers NUM_NEURONS weight words from a host and streams them to the BNN core
// as load_en-qualified nibble pairs (low nibble first), with optional idle gaps.
module bnn_weight_streamer #(
  parameter int  NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int  GAP_CYCLES  = 0,
  localparam int AW          = $clog2(NUM_NEURONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [bnn_pkg::WEIGHT_W-1:0]  wr_data,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic                          tx_load_en,
  output logic [bnn_pkg::NIBBLE_W-1:0]  tx_nibble,
  output logic [AW-1:0]                 tx_index
);

  import bnn_pkg::*;

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  load_en_q, load_en_d;
  logic [NIBBLE_W-1:0]   nibble_q, nibble_d;
  logic [AW-1:0]         index_q, index_d;

  logic [WEIGHT_W-1:0]   mem_q [NUM_NEURONS];
  logic                  wr_accept;
  logic [WEIGHT_W-1:0]   word_d;

  assign wr_accept = wr_en && !busy_q;

  // NOTE: the weight buffer is plain storage with no reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Forward a same-cycle host write so a start coinciding with a write sends the new value.
  assign word_d = (wr_accept && (wr_addr == cnt_d)) ? wr_data : mem_q[cnt_d];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_cnt_d    = gap_cnt_q;
    abort_pend_d = abort_pend_q;
    index_d      = index_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LO;
          cnt_d        = '0;
          abort_pend_d = 1'b0;
        end
      end
      LO: begin
        state_d      = HI;
        abort_pend_d = abort;
      end
      HI: begin
        index_d      = index_q + AW'(1);
        abort_pend_d = 1'b0;
        if (cnt_q == AW'(NUM_NEURONS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (abort_pend_q || abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          state_d = LO;
          cnt_d   = cnt_q + AW'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = LO;
          cnt_d   = cnt_q + AW'(1);
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they describe.
  always_comb begin
    busy_d    = (state_d != IDLE);
    load_en_d = (state_d == LO) || (state_d == HI);
    nibble_d  = '0;
    case (state_d)
      LO:      nibble_d = word_d[NIBBLE_W-1:0];
      HI:      nibble_d = word_d[WEIGHT_W-1:NIBBLE_W];
      default: nibble_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gap_cnt_q    <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      load_en_q    <= 1'b0;
      nibble_q     <= '0;
      index_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      load_en_q    <= load_en_d;
      nibble_q     <= nibble_d;
      index_q      <= index_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign tx_load_en = load_en_q;
  assign tx_nibble  = nibble_q;
  assign tx_index   = index_q;

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Scoreboard bench: dut 0 has no gaps, dut 1 inserts two idle cycles between pairs.
module tb_bnn_weight_streamer;

  typedef struct {
    logic [3:0] nib;
    logic [2:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       abort;
  logic       start_w   [2];
  logic       busy_w    [2];
  logic       done_w    [2];
  logic       aborted_w [2];
  logic       le_w      [2];
  logic [3:0] nib_w     [2];
  logic [2:0] idx_w     [2];

  exp_t sb [2][$];
  int   tests = 0;
  int   fails = 0;
  int   run      [2] = '{0, 0};
  int   last_run [2] = '{0, 0};
  int   busy_cnt [2] = '{0, 0};
  int   done_cnt [2] = '{0, 0};
  int   abrt_cnt [2] = '{0, 0};

  localparam logic [3:0] N1 [16] = '{4'h0, 4'hF, 4'hF, 4'h0, 4'hC, 4'h3, 4'h3, 4'hC,
                                     4'h0, 4'hF, 4'hF, 4'h0, 4'hC, 4'h3, 4'h3, 4'hC};
  localparam logic [3:0] N2 [16] = '{4'h5, 4'hA, 4'hA, 4'h5, 4'hC, 4'h3, 4'h3, 4'hC,
                                     4'h0, 4'hF, 4'hF, 4'h0, 4'hC, 4'h3, 4'h3, 4'hC};
  localparam logic [3:0] N3 [16] = '{4'h6, 4'h9, 4'hA, 4'h5, 4'hC, 4'h3, 4'h3, 4'hC,
                                     4'h0, 4'hF, 4'hF, 4'h0, 4'hC, 4'h3, 4'h3, 4'hC};

  always #5 clk = ~clk;

  bnn_weight_streamer #(.NUM_NEURONS(8), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_w[0]), .abort(abort), .busy(busy_w[0]), .done(done_w[0]),
    .aborted(aborted_w[0]), .tx_load_en(le_w[0]), .tx_nibble(nib_w[0]), .tx_index(idx_w[0])
  );

  bnn_weight_streamer #(.NUM_NEURONS(8), .GAP_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_w[1]), .abort(abort), .busy(busy_w[1]), .done(done_w[1]),
    .aborted(aborted_w[1]), .tx_load_en(le_w[1]), .tx_nibble(nib_w[1]), .tx_index(idx_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [3:0] nibs [16], input int n, input int base);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.nib = nibs[i];
      e.idx = 3'(base + i / 2);
      sb[d].push_back(e);
    end
  endtask

  task automatic write_word(input logic [2:0] a, input logic [7:0] v);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = v;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    start_w[d] = 1'b1;
    @(posedge clk); #1;
    start_w[d] = 1'b0;
  endtask

  // Returns how many cycles after the call the requested pulse shows up, or -1 on timeout.
  task automatic wait_pulse(input int d, input bit want_abort, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (want_abort ? aborted_w[d] : done_w[d]) begin
        cyc = i;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every load_en cycle and checks pair integrity.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        run[d] = 0;
      end else begin
        if (busy_w[d]) busy_cnt[d]++;
        if (le_w[d]) begin
          run[d]++;
          if (sb[d].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_load_en dut%0d: got nibble %0h, expected no transfer", d, nib_w[d]);
          end else begin
            e = sb[d].pop_front();
            check($sformatf("nibble_dut%0d", d), 32'(nib_w[d]), 32'(e.nib));
            check($sformatf("tx_index_dut%0d", d), 32'(idx_w[d]), 32'(e.idx));
          end
        end else if (run[d] != 0) begin
          check($sformatf("pair_even_dut%0d", d), 32'(run[d] % 2), 0);
          last_run[d] = run[d];
          run[d] = 0;
        end
        if (done_w[d] || aborted_w[d])
          check($sformatf("done_xor_aborted_dut%0d", d), 32'(done_w[d] & aborted_w[d]), 0);
        if (done_w[d])    done_cnt[d]++;
        if (aborted_w[d]) abrt_cnt[d]++;
      end
    end
  end

  initial begin
    int cyc;
    int done_before;
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    abort      = 1'b0;
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy",    32'(busy_w[0]),    0);
    check("rst_done",    32'(done_w[0]),    0);
    check("rst_aborted", 32'(aborted_w[0]), 0);
    check("rst_load_en", 32'(le_w[0]),      0);
    check("rst_nibble",  32'(nib_w[0]),     0);
    check("rst_index",   32'(idx_w[0]),     0);
    @(posedge clk); #1;

    // Burst 1: no gaps, alternating patterns.
    write_word(3'd0, 8'hF0); write_word(3'd1, 8'h0F);
    write_word(3'd2, 8'h3C); write_word(3'd3, 8'hC3);
    write_word(3'd4, 8'hF0); write_word(3'd5, 8'h0F);
    write_word(3'd6, 8'h3C); write_word(3'd7, 8'hC3);
    push(0, N1, 16, 0);
    busy_cnt[0] = 0;
    pulse_start(0);
    wait_pulse(0, 1'b0, cyc);
    check("b1_done_cycle", 32'(cyc), 17);
    check("b1_busy_cycles", 32'(busy_cnt[0]), 16);
    check("b1_load_en_run", 32'(last_run[0]), 16);
    check("b1_index_end", 32'(idx_w[0]), 0);
    check("b1_sb_empty", 32'(sb[0].size()), 0);
    check("b1_no_abort", 32'(abrt_cnt[0]), 0);

    // Burst 2: two-cycle gaps between pairs.
    write_word(3'd0, 8'hA5); write_word(3'd1, 8'h5A);
    push(1, N2, 16, 0);
    busy_cnt[1] = 0;
    pulse_start(1);
    wait_pulse(1, 1'b0, cyc);
    check("gap_done_cycle", 32'(cyc), 31);
    check("gap_busy_cycles", 32'(busy_cnt[1]), 30);
    check("gap_load_en_run", 32'(last_run[1]), 2);
    check("gap_index_end", 32'(idx_w[1]), 0);
    check("gap_sb_empty", 32'(sb[1].size()), 0);

    // Abort raised during the LO cycle of word 3: its HI still goes out.
    push(0, N2, 8, 0);
    done_before = done_cnt[0];
    busy_cnt[0] = 0;
    pulse_start(0);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_pulse(0, 1'b1, cyc);
    check("abort_cycle", 32'(cyc), 2);
    check("abort_busy_cycles", 32'(busy_cnt[0]), 8);
    check("abort_no_done", 32'(done_cnt[0]), 32'(done_before));
    check("abort_count", 32'(abrt_cnt[0]), 1);
    check("abort_index", 32'(idx_w[0]), 4);
    check("abort_load_en_run", 32'(last_run[0]), 8);
    check("abort_sb_empty", 32'(sb[0].size()), 0);

    // Host write while busy is ignored; buf[2] keeps 8'h3C.
    push(0, N2, 16, 4);
    pulse_start(0);
    repeat (3) @(posedge clk);
    #1;
    write_word(3'd2, 8'hFF);
    wait_pulse(0, 1'b0, cyc);
    check("busywr_done_cycle", 32'(cyc), 13);
    check("busywr_index", 32'(idx_w[0]), 4);
    check("busywr_sb_empty", 32'(sb[0].size()), 0);

    // Start coincident with a write to word 0: new value is sent first.
    push(0, N3, 16, 4);
    wr_en      = 1'b1;
    wr_addr    = 3'd0;
    wr_data    = 8'h96;
    start_w[0] = 1'b1;
    @(posedge clk); #1;
    wr_en      = 1'b0;
    start_w[0] = 1'b0;
    wait_pulse(0, 1'b0, cyc);
    check("samewr_done_cycle", 32'(cyc), 17);
    check("samewr_index", 32'(idx_w[0]), 4);
    check("samewr_sb_empty", 32'(sb[0].size()), 0);

    // Reset in the HI cycle of word 5.
    push(0, N3, 11, 4);
    pulse_start(0);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_load_en", 32'(le_w[0]),      0);
    check("midrst_nibble",  32'(nib_w[0]),     0);
    check("midrst_busy",    32'(busy_w[0]),    0);
    check("midrst_index",   32'(idx_w[0]),     0);
    check("midrst_done",    32'(done_w[0]),    0);
    check("midrst_aborted", 32'(aborted_w[0]), 0);
    check("midrst_sb_empty", 32'(sb[0].size()), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // After reset the next burst restarts at word 0 with the retained buffer.
    push(0, N3, 16, 0);
    pulse_start(0);
    wait_pulse(0, 1'b0, cyc);
    check("postrst_done_cycle", 32'(cyc), 17);
    check("postrst_index", 32'(idx_w[0]), 0);
    check("postrst_sb_empty", 32'(sb[0].size()), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
